// File: rtl/kmap_response_checker.sv
// Sweeps all eight 3-bit codes into a combinational unit and checks each 4-bit response against EXPECTED.
// Define KMAP_CHK_STOP_ON_FAIL_EN to end the sweep at the first mismatching code.
module kmap_response_checker #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [31:0] EXPECTED = 32'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] dut_in,
  input  logic [3:0] dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] fail_code,
  output logic [3:0] fail_val
);

  // state   | meaning
  // IDLE    | waiting for start after reset
  // SETTLE  | dut_in held, waiting SETTLE cycles for the unit to settle
  // COMPARE | one cycle: check dut_out, advance or finish
  // DONE    | results valid until next start or reset
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt, settle_cnt_nxt;
  logic [2:0] dut_in_nxt;
  logic [3:0] err_cnt_nxt;
  logic [2:0] fail_code_nxt;
  logic [3:0] fail_val_nxt;
  logic [3:0] exp_val;
  logic       mismatch;

  assign exp_val  = EXPECTED[{dut_in, 2'b00} +: 4];
  assign mismatch = (dut_out != exp_val);

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    dut_in_nxt     = dut_in;
    err_cnt_nxt    = err_cnt;
    fail_code_nxt  = fail_code;
    fail_val_nxt   = fail_val;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt      = S_SETTLE;
          settle_cnt_nxt = SETTLE_LOAD;
          dut_in_nxt     = 3'd0;
          err_cnt_nxt    = 4'd0;
          fail_code_nxt  = 3'd0;
          fail_val_nxt   = 4'd0;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == 4'd0) begin
          state_nxt = S_COMPARE;
        end else begin
          settle_cnt_nxt = settle_cnt - 4'd1;
        end
      end
      S_COMPARE: begin
        if (mismatch) begin
          err_cnt_nxt = err_cnt + 4'd1;
          if (err_cnt == 4'd0) begin
            fail_code_nxt = dut_in;
            fail_val_nxt  = dut_out;
          end
        end
        if (dut_in == 3'd7) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt      = S_SETTLE;
          settle_cnt_nxt = SETTLE_LOAD;
          dut_in_nxt     = dut_in + 3'd1;
        end
`ifdef KMAP_CHK_STOP_ON_FAIL_EN
        // Stop early and leave dut_in pointing at the failing code.
        if (mismatch) begin
          state_nxt      = S_DONE;
          settle_cnt_nxt = settle_cnt;
          dut_in_nxt     = dut_in;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      settle_cnt <= 4'd0;
      dut_in     <= 3'd0;
      err_cnt    <= 4'd0;
      fail_code  <= 3'd0;
      fail_val   <= 4'd0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      dut_in     <= dut_in_nxt;
      err_cnt    <= err_cnt_nxt;
      fail_code  <= fail_code_nxt;
      fail_val   <= fail_val_nxt;
    end
  end

  assign busy = (state == S_SETTLE) || (state == S_COMPARE);
  assign done = (state == S_DONE);
  assign pass = done && (err_cnt == 4'd0);

endmodule

// File: tb/tb_kmap_response_checker.sv
// Scoreboard bench for kmap_response_checker: stimulus queues expected sweep results,
// a monitor pops and checks them each time done rises.
module tb_kmap_response_checker;

  localparam int          SETTLE   = 2;
  localparam logic [31:0] EXPECTED = 32'h7654_3210;
  // Edges from the start-sampling edge to done; 25 edges counting the sampling edge itself.
  localparam int          FULL_LAT = 8 * (SETTLE + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] dut_in;
  logic [3:0] dut_out;
  logic       busy, done, pass;
  logic [3:0] err_cnt;
  logic [2:0] fail_code;
  logic [3:0] fail_val;

  logic [1:0] mode = 2'd0;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  typedef struct {
    int err;
    int fcode;
    int fval;
    int pss;
    int din;
    int done_cyc;
  } exp_t;
  exp_t sb[$];

  kmap_response_checker #(.SETTLE(SETTLE), .EXPECTED(EXPECTED)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_code(fail_code), .fail_val(fail_val)
  );

  // Model of the unit under test: 0 = identity, 1 = code 3 answers F, 2 = stuck at zero.
  always_comb begin
    dut_out = {1'b0, dut_in};
    if (mode == 2'd1 && dut_in == 3'd3) dut_out = 4'hF;
    if (mode == 2'd2) dut_out = 4'h0;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares on every rising edge of done.
  initial begin
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("err_cnt", int'(err_cnt), e.err);
          chk("fail_code", int'(fail_code), e.fcode);
          chk("fail_val", int'(fail_val), e.fval);
          chk("pass", int'(pass), e.pss);
          chk("dut_in_final", int'(dut_in), e.din);
          chk("busy_in_done", int'(busy), 0);
        end
      end
      done_q = done;
    end
  end

  // Pulse start from a negedge; returns the cycle number assigned by the sampling edge.
  task automatic pulse_start(output int k);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_exp(input int err, input int fcode, input int fval, input int pss,
                          input int din, input int done_cyc);
    exp_t e;
    e.err = err; e.fcode = fcode; e.fval = fval; e.pss = pss; e.din = din; e.done_cyc = done_cyc;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic wait_code(input int code);
    int n;
    n = 0;
    while (int'(dut_in) != code && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_code", int'(dut_in), code);
  endtask

  initial begin
    int k;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_din", int'(dut_in), 0);
    #20;
    rst = 1'b1;

    // Clean sweep: every code answered correctly.
    mode = 2'd0;
    pulse_start(k);
    chk("start_busy", int'(busy), 1);
    push_exp(0, 0, 0, 1, 7, k + FULL_LAT);
    wait_drain("clean");

    // Restart straight from DONE: done drops on the start edge, results repeat.
    chk("done_before_restart", int'(done), 1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    chk("restart_done_drop", int'(done), 0);
    chk("restart_err_clr", int'(err_cnt), 0);
    chk("restart_busy", int'(busy), 1);
    push_exp(0, 0, 0, 1, 7, k + FULL_LAT);
    @(negedge clk);
    start = 1'b0;
    wait_drain("restart");

    // Code 3 returns F.
    mode = 2'd1;
    pulse_start(k);
    push_exp(1, 3, 15, 0, 7, k + FULL_LAT);
    wait_drain("code3_bad");

    // Unit stuck at zero: only code 0 matches.
    mode = 2'd2;
    pulse_start(k);
`ifdef KMAP_CHK_STOP_ON_FAIL_EN
    push_exp(1, 1, 0, 0, 1, k + 2 * (SETTLE + 1));
`else
    push_exp(7, 1, 0, 0, 7, k + FULL_LAT);
`endif
    wait_drain("stuck_zero");

    // Start during SETTLE of code 4 is ignored; done timing unchanged.
    mode = 2'd0;
    pulse_start(k);
    push_exp(0, 0, 0, 1, 7, k + FULL_LAT);
    wait_code(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("start_ignored");

    // Asynchronous reset mid-sweep during code 5.
    pulse_start(k);
    wait_code(5);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_din", int'(dut_in), 0);
    chk("async_rst_err", int'(err_cnt), 0);
    chk("async_rst_pass", int'(pass), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_after_abort", int'(done), 0);
    chk("idle_after_abort", int'(busy), 0);

    // New start after reset gives a full clean sweep.
    pulse_start(k);
    push_exp(0, 0, 0, 1, 7, k + FULL_LAT);
    wait_drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
